// File: rtl/network_request_arbiter_pkg.sv
// Shared FSM encoding and default field widths for the network request arbiter.
// Pure declarations; no latency or backpressure of its own.
package network_request_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  localparam int DEF_DEV_WIDTH  = 16;
  localparam int DEF_ADDR_WIDTH = 36;
  localparam int DEF_LEN_WIDTH  = 36;

endpackage

// File: rtl/network_request_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request at or above ptr, wrapping to 0.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module rr_priority_picker #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_WIDTH = 3
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic                 found,
  output logic [IDX_WIDTH-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Upper pass covers ptr..NUM_REQ-1; the lower pass only matters when that found nothing.
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j] && (IDX_WIDTH'(j) >= ptr)) begin
        found = 1'b1;
        idx   = IDX_WIDTH'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDX_WIDTH'(j);
      end
    end
  end

endmodule

// File: rtl/network_request_arbiter.sv
// Round-robin owner of the network request channel; ARB_WATCHDOG_EN adds a grant watchdog.
// Latency: net_request 1 cycle after request seen. Backpressure: owner holds the channel until net_complete (or watchdog).
module network_request_arbiter
  import network_request_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int DEV_WIDTH      = DEF_DEV_WIDTH,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int IDX_WIDTH      = 3,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_request,
  input  logic [NUM_REQ*DEV_WIDTH-1:0]    req_device,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]    req_length,
  output logic [NUM_REQ-1:0]              req_ack,
  output logic [NUM_REQ-1:0]              req_complete,
  output logic                            net_request,
  output logic [DEV_WIDTH-1:0]            net_device,
  output logic [ADDR_WIDTH-1:0]           net_address,
  output logic [LEN_WIDTH-1:0]            net_length,
  input  logic                            net_ack,
  input  logic                            net_complete,
  output logic                            grant_valid,
  output logic [IDX_WIDTH-1:0]            grant_id,
  output logic                            timeout_error
);

  if (((1 << IDX_WIDTH) < NUM_REQ) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
    $error("network_request_arbiter: IDX_WIDTH too narrow or TIMEOUT_CYCLES < 1");
  end

  typedef struct packed {
    logic [LEN_WIDTH-1:0]  len;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DEV_WIDTH-1:0]  dev;
  } fields_t;

  arb_state_t           state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, gid_q, pick_idx, rr_next;
  logic                 pick_found, grant_take, complete_fire, grant_valid_q, wd_fire;
  logic [NUM_REQ-1:0]   owner_oh;
  fields_t              fields_q, pick_fields;

  rr_priority_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .req   (req_request),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    pick_fields = '0;
    owner_oh    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_idx == IDX_WIDTH'(j)) begin
        pick_fields.dev  = req_device[j*DEV_WIDTH +: DEV_WIDTH];
        pick_fields.addr = req_address[j*ADDR_WIDTH +: ADDR_WIDTH];
        pick_fields.len  = req_length[j*LEN_WIDTH +: LEN_WIDTH];
      end
      owner_oh[j] = (gid_q == IDX_WIDTH'(j));
    end
  end

  assign rr_next = (gid_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    grant_take    = 1'b0;
    complete_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_take = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (net_ack) begin
          complete_fire = net_complete;
          state_d       = net_complete ? RELEASE : BUSY;
        end
        if (wd_fire) begin
          complete_fire = 1'b1;
          state_d       = RELEASE;
        end
      end
      BUSY: begin
        if (net_complete || wd_fire) begin
          complete_fire = 1'b1;
          state_d       = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      gid_q         <= '0;
      fields_q      <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_take) begin
        gid_q         <= pick_idx;
        fields_q      <= pick_fields;
        grant_valid_q <= 1'b1;
      end
      if (state_q == RELEASE) begin
        grant_valid_q <= 1'b0;
        rr_ptr_q      <= rr_next;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  logic [31:0] wd_cnt_q;
  logic        timeout_q;

  assign wd_fire = ((state_q == ISSUE) || (state_q == BUSY)) &&
                   (wd_cnt_q == 32'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (grant_take) begin
        wd_cnt_q <= '0;
      end else if ((state_q == ISSUE) || (state_q == BUSY)) begin
        wd_cnt_q <= wd_cnt_q + 32'd1;
      end
      if (wd_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout_error = timeout_q;
`else
  assign wd_fire       = 1'b0;
  assign timeout_error = 1'b0;
`endif

  // Ack is only meaningful while the request is outstanding; IDLE/RELEASE pulses are dropped.
  assign req_ack      = ((state_q == ISSUE) && net_ack) ? owner_oh : '0;
  assign req_complete = complete_fire ? owner_oh : '0;
  assign net_request  = (state_q == ISSUE);
  assign net_device   = fields_q.dev;
  assign net_address  = fields_q.addr;
  assign net_length   = fields_q.len;
  assign grant_valid  = grant_valid_q;
  assign grant_id     = gid_q;

endmodule

// File: tb/tb_network_request_arbiter.sv
// Directed bench for network_request_arbiter with two requesters and a 20-cycle watchdog limit.
module tb_network_request_arbiter;

  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 36;
  localparam int LW = 36;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_request;
  logic [N*DW-1:0] req_device;
  logic [N*AW-1:0] req_address;
  logic [N*LW-1:0] req_length;
  logic [N-1:0]    req_ack, req_complete;
  logic            net_request, net_ack, net_complete;
  logic [DW-1:0]   net_device;
  logic [AW-1:0]   net_address;
  logic [LW-1:0]   net_length;
  logic            grant_valid, timeout_error;
  logic [IW-1:0]   grant_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  network_request_arbiter #(
    .NUM_REQ(N), .DEV_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
    .IDX_WIDTH(IW), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst),
    .req_request(req_request), .req_device(req_device),
    .req_address(req_address), .req_length(req_length),
    .req_ack(req_ack), .req_complete(req_complete),
    .net_request(net_request), .net_device(net_device),
    .net_address(net_address), .net_length(net_length),
    .net_ack(net_ack), .net_complete(net_complete),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .timeout_error(timeout_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_request = '0; net_ack = 1'b0; net_complete = 1'b0;
    req_device  = {16'h0011, 16'h0003};
    req_address = {36'h2000, 36'h1000};
    req_length  = {36'd128, 36'd64};

    cyc(); cyc();
    chk("rst_net_request", 64'(net_request), 64'd0);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_id", 64'(grant_id), 64'd0);
    chk("rst_net_device", 64'(net_device), 64'd0);
    chk("rst_timeout", 64'(timeout_error), 64'd0);
    rst = 1'b0;

    // single requester: ack 2 cycles after request, complete 10 cycles after
    cyc();
    req_request = 2'b01; #1;
    chk("t1_no_req_yet", 64'(net_request), 64'd0);
    cyc();
    chk("t1_net_request", 64'(net_request), 64'd1);
    chk("t1_grant_valid", 64'(grant_valid), 64'd1);
    chk("t1_grant_id", 64'(grant_id), 64'd0);
    chk("t1_dev", 64'(net_device), 64'h3);
    chk("t1_addr", 64'(net_address), 64'h1000);
    chk("t1_len", 64'(net_length), 64'd64);
    chk("t1_no_ack_yet", 64'(req_ack), 64'd0);
    cyc();
    net_ack = 1'b1; #1;
    chk("t1_req_ack", 64'(req_ack), 64'b01);
    cyc();
    net_ack = 1'b0; req_request = 2'b00; #1;
    chk("t1_busy_net_request", 64'(net_request), 64'd0);
    chk("t1_ack_single", 64'(req_ack), 64'd0);
    chk("t1_dev_held", 64'(net_device), 64'h3);
    for (int i = 0; i < 7; i++) cyc();
    chk("t1_no_cpl_yet", 64'(req_complete), 64'd0);
    net_complete = 1'b1; #1;
    chk("t1_req_complete", 64'(req_complete), 64'b01);
    cyc();
    net_complete = 1'b0; #1;
    chk("t1_cpl_single", 64'(req_complete), 64'd0);
    cyc();
    chk("t1_grant_released", 64'(grant_valid), 64'd0);

    // contention: grants 0, 1, 0
    do_reset();
    req_request = 2'b11;
    cyc();
    chk("t2_first_id", 64'(grant_id), 64'd0);
    chk("t2_first_dev", 64'(net_device), 64'h3);
    net_ack = 1'b1; #1;
    chk("t2_ack0", 64'(req_ack), 64'b01);
    cyc();
    net_ack = 1'b0; req_request = 2'b10; net_complete = 1'b1; #1;
    chk("t2_cpl0", 64'(req_complete), 64'b01);
    cyc();
    net_complete = 1'b0; req_request = 2'b11;
    cyc();
    chk("t2_idle_gap", 64'(net_request), 64'd0);
    cyc();
    chk("t2_second_id", 64'(grant_id), 64'd1);
    chk("t2_second_dev", 64'(net_device), 64'h11);
    chk("t2_second_addr", 64'(net_address), 64'h2000);
    net_ack = 1'b1; #1;
    chk("t2_ack1", 64'(req_ack), 64'b10);
    cyc();
    net_ack = 1'b0; req_request = 2'b01; net_complete = 1'b1; #1;
    chk("t2_cpl1", 64'(req_complete), 64'b10);
    cyc();
    net_complete = 1'b0;
    cyc(); cyc();
    chk("t2_third_id", 64'(grant_id), 64'd0);
    chk("t2_third_len", 64'(net_length), 64'd64);

    // same-cycle ack and complete in ISSUE (owner 0)
    net_ack = 1'b1; net_complete = 1'b1; #1;
    chk("t3_ack", 64'(req_ack), 64'b01);
    chk("t3_cpl", 64'(req_complete), 64'b01);
    cyc();
    net_ack = 1'b0; net_complete = 1'b0; req_request = 2'b00;
    cyc();
    chk("t3_idle_grant_valid", 64'(grant_valid), 64'd0);
    chk("t3_idle_net_request", 64'(net_request), 64'd0);

    // spurious pulses in IDLE
    net_ack = 1'b1; net_complete = 1'b1; #1;
    chk("t4_no_cpl", 64'(req_complete), 64'd0);
    chk("t4_no_ack", 64'(req_ack), 64'd0);
    cyc();
    net_ack = 1'b0; net_complete = 1'b0; #1;
    chk("t4_still_idle", 64'(grant_valid), 64'd0);
    chk("t4_no_net_request", 64'(net_request), 64'd0);

    // reset while requester 1 owns the channel in BUSY (pointer is 1 here)
    req_request = 2'b10;
    cyc();
    chk("t5_owner", 64'(grant_id), 64'd1);
    net_ack = 1'b1;
    cyc();
    net_ack = 1'b0; req_request = 2'b00;
    #3 rst = 1'b1; net_complete = 1'b1; #1;
    chk("t5_async_grant_valid", 64'(grant_valid), 64'd0);
    chk("t5_async_grant_id", 64'(grant_id), 64'd0);
    chk("t5_async_dev", 64'(net_device), 64'd0);
    chk("t5_async_cpl", 64'(req_complete), 64'd0);
    cyc();
    net_complete = 1'b0; rst = 1'b0; req_request = 2'b11;
    cyc();
    chk("t5_restart_id", 64'(grant_id), 64'd0);
    req_request = 2'b00;
    net_ack = 1'b1; net_complete = 1'b1;
    cyc();
    net_ack = 1'b0; net_complete = 1'b0;
    cyc();

`ifdef ARB_WATCHDOG_EN
    do_reset();
    req_request = 2'b11;
    cyc();
    chk("t6_owner", 64'(grant_id), 64'd0);
    for (int i = 0; i < 19; i++) cyc();
    chk("t6_no_cpl_early", 64'(req_complete), 64'd0);
    chk("t6_no_err_early", 64'(timeout_error), 64'd0);
    cyc();
    chk("t6_wd_cpl", 64'(req_complete), 64'b01);
    req_request = 2'b10;
    cyc();
    chk("t6_err_sticky", 64'(timeout_error), 64'd1);
    chk("t6_cpl_pulse", 64'(req_complete), 64'd0);
    cyc(); cyc();
    chk("t6_next_owner", 64'(grant_id), 64'd1);
    chk("t6_err_held", 64'(timeout_error), 64'd1);
`else
    chk("t6_no_watchdog", 64'(timeout_error), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/network_request_arbiter.md
Name: network_request_arbiter

Overview:
- Shares the single network master request channel between NUM_REQ transaction requesters, e.g. the pixel fetcher (reads) and the result storer (writes) in the skintone pipeline.
- Round-robin arbitration; one transaction owns the channel from grant until its completion.
- Latches each winner's device/address/length, drives them to the network, routes ack/complete back to the owner only.
- Exports the owner index so the surrounding datapath can steer data-in and data-out handshakes.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- DEV_WIDTH, 16, device id width.
- ADDR_WIDTH, 36, address width.
- LEN_WIDTH, 36, length width.
- IDX_WIDTH, 3, width of the grant index (must satisfy 2^IDX_WIDTH >= NUM_REQ).
- TIMEOUT_CYCLES, 65535, watchdog limit (used only with the macro).

Ports:
- clk  input  1  sole clock.
- rst  input  1  asynchronous, active-high reset.
- req_request  input  NUM_REQ  per-requester request level.
- req_device  input  NUM_REQ*DEV_WIDTH  flattened; requester i occupies slice i.
- req_address  input  NUM_REQ*ADDR_WIDTH  flattened.
- req_length  input  NUM_REQ*LEN_WIDTH  flattened.
- req_ack  output  NUM_REQ  one-hot acknowledge to the owner.
- req_complete  output  NUM_REQ  one-hot completion to the owner.
- net_request  output  1  request to the network.
- net_device  output  DEV_WIDTH  latched device.
- net_address  output  ADDR_WIDTH  latched address.
- net_length  output  LEN_WIDTH  latched length.
- net_ack  input  1  network acknowledge (1-cycle pulse).
- net_complete  input  1  network completion (1-cycle pulse).
- grant_valid  output  1  a transaction owns the channel.
- grant_id  output  IDX_WIDTH  index of the owner.
- timeout_error  output  1  sticky watchdog flag (macro only; tied 0 otherwise).

Behaviour:
- Reset (async, immediate): state IDLE; rr pointer 0; all outputs 0; latched fields 0.
- FSM states:
  - IDLE: if any req_request bit is set, pick the first set bit searching upward from the rr pointer, wrapping modulo NUM_REQ. Latch that requester's fields and grant_id, set grant_valid, go to ISSUE. net_request rises on the next cycle, so latency is 1 cycle from request seen to net_request high.
  - ISSUE: net_request=1 and fields held stable. On net_ack: req_ack[grant_id]=net_ack (combinational, gated by state and owner), drop net_request, go to BUSY.
  - ISSUE with net_ack and net_complete in the same cycle: forward both to the owner and go directly to RELEASE.
  - BUSY: wait. On net_complete: req_complete[grant_id]=1 in that cycle, go to RELEASE.
  - RELEASE: clear grant_valid; rr pointer = (grant_id+1) wrapped modulo NUM_REQ (wrap at NUM_REQ-1 -> 0); return to IDLE. Back-to-back grants are therefore separated by one idle-arbitration cycle.
- A net_ack or net_complete arriving in IDLE or RELEASE is ignored and never forwarded.
- A requester dropping req_request after grant does not cancel the transaction; the latched fields are used.
- A requester must hold req_request until req_ack. It is re-eligible only after RELEASE.
- grant_id and the net_* fields are stable for the whole grant.
- Asserting reset mid-transaction returns the block to IDLE immediately. The network side is assumed to be reset with it.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- With it: a 32-bit counter clears on grant and increments in ISSUE/BUSY. On reaching TIMEOUT_CYCLES the block:
  - sets timeout_error (sticky until reset),
  - pulses req_complete[grant_id] for one cycle,
  - goes to RELEASE.
- Without it: no counter; timeout_error is tied 0; the block waits indefinitely.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE, ISSUE, BUSY, RELEASE),
  - default width constants for DEV/ADDR/LEN widths.
- One natural sub-module: rr_priority_picker. It is combinational; given the request vector and the pointer it returns a found flag and an index. This lets it be reused by a future data-channel arbiter.

Test Plan:
- Single requester: req 0 requests dev=0x0003, addr=0x1000, len=64; net_ack 2 cycles later, net_complete 10 cycles later -> net_request high 1 cycle after request; req_ack[0] and req_complete[0] pulse once; grant_valid falls the cycle after complete.
- Contention: both request in the same cycle after reset -> req 0 is granted first, req 1 next, req 0 after that if it requests again; grant_id sequence 0,1,0.
- Same-cycle net_ack and net_complete in ISSUE -> both forwarded to the owner in one cycle; block is IDLE 2 cycles later.
- Spurious net_complete in IDLE -> no req_complete bit set; state stays IDLE.
- Reset asserted in BUSY with req 1 owner -> all outputs 0 without waiting for a clock edge; next grant searches from index 0.
- ARB_WATCHDOG_EN with TIMEOUT_CYCLES=20, no net_complete -> timeout_error=1 and req_complete[owner] pulses 20 cycles after grant; channel released; the other requester is granted next.
